// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle core: result/address selects, branch
// funct3 values, opcodes and the reset NOP.
package core_pkg;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } resultsrc_e;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_ir_datapath_branch_cond.sv
// Branch-taken decode from funct3 and the ALU flags of the current cycle.
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = ~alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = ~alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = ~alu_ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ir_datapath.sv
// Non-architectural state of the multi-cycle core (PC, OldPC, IR, MDR, A, B,
// ALUOut) with PC-write resolution and the address/result muxes.
module pc_ir_datapath
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcupdate,
    input  logic            branch,
    input  logic            irwrite,
    input  logic            adrsrc,
    input  logic [1:0]      resultsrc,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] a_q,
    output logic [XLEN-1:0] b_q,
    output logic [XLEN-1:0] aluout_q,
    output logic            pc_write,
    output logic            pc_misalign,
    output logic [31:0]     instret
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] a_d, b_d, aluout_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     instret_q, instret_d;
    logic            taken;

    branch_cond u_branch_cond (
        .funct3   (instr_q[14:12]),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (taken)
    );

    always_comb begin
        result = aluout_q;
        case (resultsrc)
            RES_DATA:      result = mdr_q;
            RES_ALURESULT: result = alu_result;
            default:       result = aluout_q;
        endcase
    end

    always_comb begin
        pc_write   = pcupdate | (branch & taken);
        pc_d       = pc_write ? result : pc_q;
        misalign_d = misalign_q | (pc_write & (result[1:0] != 2'b00));
        // OldPC samples the pre-write PC so a fetch that also bumps PC records its own address
        old_pc_d   = irwrite ? pc_q : old_pc_q;
        instr_d    = irwrite ? mem_rdata : instr_q;
        instret_d  = irwrite ? instret_q + 32'd1 : instret_q;
        mdr_d      = mem_rdata;
        a_d        = rd1;
        b_d        = rd2;
        aluout_d   = alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            old_pc_q   <= '0;
            instr_q    <= XLEN'(NOP_INSTR);
            mdr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            aluout_q   <= '0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            old_pc_q   <= old_pc_d;
            instr_q    <= instr_d;
            mdr_q      <= mdr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            aluout_q   <= aluout_d;
            misalign_q <= misalign_d;
            instret_q  <= instret_d;
        end
    end

    assign mem_addr    = (adrsrc == ADR_RESULT) ? result : pc_q;
    assign pc          = pc_q;
    assign old_pc      = old_pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign pc_misalign = misalign_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_ir_datapath.sv
// Directed-vector bench for pc_ir_datapath; inputs change on negedge, outputs checked at negedge.
module tb_pc_ir_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcupdate, branch, irwrite, adrsrc;
    logic [1:0]  resultsrc;
    logic [31:0] alu_result, mem_rdata, rd1, rd2;
    logic        alu_zero, alu_lt, alu_ltu;
    logic [31:0] mem_addr, result, pc, old_pc, instr, a_q, b_q, aluout_q, instret;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        pc_write, pc_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_ir_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .pcupdate(pcupdate), .branch(branch), .irwrite(irwrite),
        .adrsrc(adrsrc), .resultsrc(resultsrc), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_rdata(mem_rdata),
        .rd1(rd1), .rd2(rd2), .mem_addr(mem_addr), .result(result), .pc(pc),
        .old_pc(old_pc), .instr(instr), .op(op), .funct3(funct3), .a_q(a_q), .b_q(b_q),
        .aluout_q(aluout_q), .pc_write(pc_write), .pc_misalign(pc_misalign), .instret(instret)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pcupdate = 0; branch = 0; irwrite = 0; adrsrc = 0; resultsrc = 2'b00;
        alu_zero = 0; alu_lt = 0; alu_ltu = 0;
    endtask

    // Fetch cycle: IR <= word, PC <= next_pc through the alu_result path.
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] next_pc);
        idle();
        irwrite = 1; pcupdate = 1; resultsrc = 2'b10;
        alu_result = next_pc; mem_rdata = word;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        alu_result = 0; mem_rdata = 0; rd1 = 0; rd2 = 0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
        checks++; if (op !== 7'b0010011) begin errors++; $display("FAIL reset_op got %b exp %b", op, 7'b0010011); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %h exp 0", instret); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL reset_mem_addr got %h exp %h", mem_addr, 32'h100); end
        checks++; if (pc_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", pc_misalign); end
    endtask

    task automatic test_fetch();
        irwrite = 1; pcupdate = 1; resultsrc = 2'b10;
        alu_result = 32'h104; mem_rdata = 32'h00A00093;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL fetch_pc_write got %b exp 1", pc_write); end
        checks++; if (result !== 32'h104) begin errors++; $display("FAIL fetch_result got %h exp %h", result, 32'h104); end
        tick();
        idle();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL fetch_pc got %h exp %h", pc, 32'h104); end
        checks++; if (old_pc !== 32'h100) begin errors++; $display("FAIL fetch_old_pc got %h exp %h", old_pc, 32'h100); end
        checks++; if (instr !== 32'h00A00093) begin errors++; $display("FAIL fetch_instr got %h exp %h", instr, 32'h00A00093); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL fetch_instret got %h exp 1", instret); end
    endtask

    task automatic test_beq();
        do_fetch(32'h0000_0063, 32'h108);       // beq, pc -> 108
        checks++; if (funct3 !== 3'b000) begin errors++; $display("FAIL beq_funct3 got %b exp 000", funct3); end
        alu_result = 32'h200;
        tick();                                  // aluout_q <= 200
        branch = 1; resultsrc = 2'b00; alu_zero = 1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL beq_taken_pc_write got %b exp 1", pc_write); end
        checks++; if (result !== 32'h200) begin errors++; $display("FAIL beq_result got %h exp %h", result, 32'h200); end
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL beq_taken_pc got %h exp %h", pc, 32'h200); end
        alu_zero = 0; alu_result = 32'h300;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL beq_nt_pc_write got %b exp 0", pc_write); end
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL beq_nt_pc got %h exp %h", pc, 32'h200); end
        idle();
    endtask

    task automatic test_cond_decode();
        do_fetch(32'h0000_6063, 32'h204);       // bltu
        branch = 1; alu_ltu = 1; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bltu_taken got %b exp 1", pc_write); end
        alu_ltu = 0; #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bltu_nt got %b exp 0", pc_write); end
        do_fetch(32'h0000_5063, 32'h208);       // bge
        branch = 1; alu_lt = 1; #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bge_lt got %b exp 0", pc_write); end
        alu_lt = 0; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bge_ge got %b exp 1", pc_write); end
        do_fetch(32'h0000_1063, 32'h20C);       // bne
        branch = 1; alu_zero = 0; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bne_ne got %b exp 1", pc_write); end
        do_fetch(32'h0000_7063, 32'h210);       // bgeu
        branch = 1; alu_ltu = 1; #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bgeu_ltu got %b exp 0", pc_write); end
        do_fetch(32'h0000_2063, 32'h214);       // funct3 010, never taken
        branch = 1;
        for (int f = 0; f < 8; f++) begin
            {alu_zero, alu_lt, alu_ltu} = f[2:0];
            #1;
            checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL f3_010_flags%0d got %b exp 0", f, pc_write); end
        end
        pcupdate = 1; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL branch_or_pcupdate got %b exp 1", pc_write); end
        idle();
    endtask

    task automatic test_load_path();
        alu_result = 32'h40; rd1 = 32'h1111_2222; rd2 = 32'h3333_4444;
        tick();
        checks++; if (a_q !== 32'h1111_2222) begin errors++; $display("FAIL a_q got %h exp %h", a_q, 32'h1111_2222); end
        checks++; if (b_q !== 32'h3333_4444) begin errors++; $display("FAIL b_q got %h exp %h", b_q, 32'h3333_4444); end
        adrsrc = 1; resultsrc = 2'b00; mem_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL load_mem_addr got %h exp %h", mem_addr, 32'h40); end
        tick();
        adrsrc = 0; resultsrc = 2'b01; mem_rdata = 32'h0; #1;
        checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_mdr_result got %h exp %h", result, 32'hDEAD_BEEF); end
        resultsrc = 2'b11; #1;
        checks++; if (result !== 32'h40) begin errors++; $display("FAIL resultsrc11 got %h exp %h", result, 32'h40); end
        idle();
    endtask

    task automatic test_instret_wrap();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", instret); end
        irwrite = 1; mem_rdata = 32'h0000_0013;
        tick();
        idle();
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL wrap_instret got %h exp 0", instret); end
    endtask

    task automatic test_misalign();
        checks++; if (pc_misalign !== 1'b0) begin errors++; $display("FAIL misalign_pre got %b exp 0", pc_misalign); end
        pcupdate = 1; resultsrc = 2'b10; alu_result = 32'h102;
        tick();
        checks++; if (pc !== 32'h102) begin errors++; $display("FAIL misalign_pc got %h exp %h", pc, 32'h102); end
        checks++; if (pc_misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got %b exp 1", pc_misalign); end
        alu_result = 32'h104;
        tick();
        tick();
        checks++; if (pc_misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b exp 1", pc_misalign); end
        idle();
    endtask

    task automatic test_reset_mid_branch();
        do_fetch(32'h0000_0063, 32'h300);
        rd1 = 32'h5; rd2 = 32'h6; alu_result = 32'h7; mem_rdata = 32'h8;
        tick();
        branch = 1; alu_zero = 1; resultsrc = 2'b00;
        #2;
        rst = 1;
        #1;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_mid_pc got %h exp %h", pc, 32'h100); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rst_mid_instr got %h exp 13", instr); end
        checks++; if (old_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_old_pc got %h exp 0", old_pc); end
        checks++; if ({a_q, b_q, aluout_q} !== 96'h0) begin errors++; $display("FAIL rst_mid_regs got %h %h %h exp 0", a_q, b_q, aluout_q); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rst_mid_instret got %h exp 0", instret); end
        checks++; if (pc_misalign !== 1'b0) begin errors++; $display("FAIL rst_mid_misalign got %b exp 0", pc_misalign); end
        resultsrc = 2'b01; #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_mdr got %h exp 0", result); end
        idle();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_beq();
        test_cond_decode();
        test_load_path();
        test_instret_wrap();
        test_misalign();
        test_reset_mid_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ir_datapath.md
# pc_ir_datapath

Sequential datapath slice sitting directly downstream of the multi-cycle control FSM. It holds the non-architectural state of the multi-cycle core: PC, OldPC, instruction register, memory data register, A/B operand registers and ALUOut. It resolves PC writes, meaning both unconditional PC updates and conditional branches decoded from funct3 and the ALU flags. It drives the memory address mux and the result mux, and feeds op/funct3 back to the FSM and decoders.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pcupdate  in  1  FSM: unconditional PC write.
- branch  in  1  FSM: conditional PC write, gated by the branch condition.
- irwrite  in  1  FSM: load IR and OldPC.
- adrsrc  in  1  FSM: memory address select (0 = PC, 1 = result).
- resultsrc  in  2  FSM: result select (00 = ALUOut, 01 = MDR, 10 = alu_result, 11 = ALUOut).
- alu_result  in  XLEN  combinational ALU output.
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags for the current operation: equal, signed less-than, unsigned less-than.
- mem_rdata  in  XLEN  memory read data.
- rd1, rd2  in  XLEN  register-file read ports.
- mem_addr  out  XLEN  memory address.
- result  out  XLEN  result bus (register-file write data and PC next value).
- pc, old_pc, instr  out  XLEN  register contents.
- op  out  7  instr[6:0]; funct3  out  3  instr[14:12].
- a_q, b_q, aluout_q  out  XLEN  operand and ALUOut registers; b_q is also the store data.
- pc_write  out  1  combinational PC write enable.
- pc_misalign  out  1  sticky misaligned-PC flag.
- instret  out  32  fetch counter.

## Operation
- result mux: selected per resultsrc. Code 11 is treated as 00.
- mem_addr = adrsrc ? result : pc.
- Branch condition, decoded from funct3:
  - 000 beq: alu_zero.
  - 001 bne: !alu_zero.
  - 100 blt: alu_lt.
  - 101 bge: !alu_lt.
  - 110 bltu: alu_ltu.
  - 111 bgeu: !alu_ltu.
  - 010 and 011: never taken.
- pc_write = pcupdate | (branch & taken).
- On pc_write, pc <= result, written unmodified.
- If pc_write and result[1:0] != 0, pc_misalign is set. It stays set until reset.
- On irwrite: instr <= mem_rdata, old_pc <= pc (the value before any same-cycle PC write), instret <= instret + 1.
- instret wraps from 32'hFFFF_FFFF to 0.
- The following load unconditionally every cycle:
  - mdr <= mem_rdata.
  - a_q <= rd1, b_q <= rd2.
  - aluout_q <= alu_result.
- Simultaneous irwrite and pcupdate (the fetch state) is legal. IR and OldPC capture the old PC's fetch, and PC takes PC+4 via result = alu_result.
- branch and pcupdate both high: the PC is written (OR semantics).

## Timing
- All registers update on posedge clk. mem_addr, result, pc_write, op and funct3 are combinational from register state and inputs, with zero latency.
- Reset (asynchronous, immediate, valid mid-instruction):
  - pc = RESET_PC.
  - instr = 32'h0000_0013 (NOP), so op = 7'b0010011.
  - old_pc, mdr, a_q, b_q, aluout_q = 0.
  - instret = 0.
  - pc_misalign = 0.
- Data loaded by a memory read is visible on mdr one cycle after mem_rdata is presented. This matches the FSM's read-address state followed by its writeback state.
- The branch decision uses the ALU flags of the same cycle in which branch = 1. No state is held across cycles.

## Structure
- Shared package core_pkg:
  - Branch funct3 constants.
  - resultsrc encoding enum (RES_ALUOUT, RES_DATA, RES_ALURESULT).
  - adrsrc constants.
  - Opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH).
  - NOP_INSTR.
- One combinational sub-module, branch_cond (funct3, alu_zero, alu_lt, alu_ltu -> taken). All registers live in the top.

## Test plan
- Reset release with RESET_PC = 32'h100 -> pc = 32'h100, op = 7'b0010011, instret = 0, mem_addr = 32'h100.
- Fetch cycle: irwrite = 1, pcupdate = 1, resultsrc = 10, alu_result = 32'h104, mem_rdata = 32'h00A00093 -> next cycle pc = 32'h104, old_pc = 32'h100, instr = 32'h00A00093, instret = 1.
- beq (funct3 = 000), branch = 1, resultsrc = 00:
  - alu_zero = 1, aluout_q = 32'h200 -> pc = 32'h200.
  - alu_zero = 0 -> pc unchanged.
- bltu/bge: funct3 = 110 with alu_ltu = 1 -> pc_write = 1. funct3 = 101 with alu_lt = 1 -> pc_write = 0. funct3 = 010 -> pc_write = 0 for any flags.
- Load path: adrsrc = 1, resultsrc = 00, aluout_q = 32'h40 -> mem_addr = 32'h40. Next cycle resultsrc = 01 -> result = the sampled mem_rdata.
- Boundaries:
  - instret preloaded (via forced fetches) to 32'hFFFF_FFFF, then irwrite -> instret = 0.
  - pcupdate with result = 32'h102 -> pc_misalign = 1 and stays set.
  - rst asserted mid-branch -> all outputs return to reset values in the same cycle.
